// File: rtl/fifo8x9_pkg.sv
// Shared sizing defaults and controller state encoding for the FIFO8x9 controller.
package fifo8x9_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 4;
  localparam int IDX_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/fifo8x9_ptr_wrap.sv
// Shadow index of one FIFO8x9 pointer; turns an advance request into either an
// increment or a clear so the external pointer never passes DEPTH-1.
module fifo8x9_ptr_wrap #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_inc,
  output logic o_wrap
);
  logic [IDX_W-1:0] r_idx;
  logic             w_last;

  assign w_last = (r_idx == IDX_W'(DEPTH - 1));
  assign o_wrap = i_adv & w_last;
  assign o_inc  = i_adv & ~w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= '0;
    end else if (i_adv) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/fifo8x9_ctrl.sv
// Control-only front end for the FIFO8x9 storage array: accepts push/pop/flush,
// drives the array's enable and pointer strobes, and tracks occupancy.
module fifo8x9_ctrl
  import fifo8x9_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic             wren,
  output logic             WrInc,
  output logic             WrPtrClr,
  output logic             rden,
  output logic             RdInc,
  output logic             RdPtrClr,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             rd_valid,
  output logic             overflow,
  output logic             underflow
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_run;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_clr_st;
  logic             w_wr_inc;
  logic             w_wr_wrap;
  logic             w_rd_inc;
  logic             w_rd_wrap;

  // Flags come only from the registered count, never from push/pop.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_clr_st = (r_state == ST_CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_CLEAR: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (flush) w_state_nxt = ST_CLEAR;
        else       w_run       = ~rst;
      end
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // A pop frees a slot for a same-cycle push, but a push never feeds a same-cycle pop.
  assign w_pop_ok  = w_run & pop & ~w_empty;
  assign w_push_ok = w_run & push & (~w_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_RUN && flush)) begin
      r_count <= '0;
    end else if (w_push_ok && !w_pop_ok) begin
      r_count <= r_count + 1'b1;
    end else if (w_pop_ok && !w_push_ok) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid  <= w_pop_ok;
      r_overflow  <= w_run & push & ~w_push_ok;
      r_underflow <= w_run & pop & ~w_pop_ok;
    end
  end

  fifo8x9_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_wr_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr_st),
    .i_adv  (w_push_ok),
    .o_inc  (w_wr_inc),
    .o_wrap (w_wr_wrap)
  );

  fifo8x9_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_rd_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr_st),
    .i_adv  (w_pop_ok),
    .o_inc  (w_rd_inc),
    .o_wrap (w_rd_wrap)
  );

  assign wren      = w_push_ok;
  assign WrInc     = w_wr_inc;
  assign WrPtrClr  = w_clr_st | w_wr_wrap;
  assign rden      = w_pop_ok;
  assign RdInc     = w_rd_inc;
  assign RdPtrClr  = w_clr_st | w_rd_wrap;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign rd_valid  = r_rd_valid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Bench for fifo8x9_ctrl: a stand-in FIFO8x9 array driven by the controller's
// strobes, checked against a queue-based model of the FIFO behaviour.
module tb_fifo8x9_ctrl;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst, push, pop, flush;
  logic       wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr;
  logic       full, empty, rd_valid, overflow, underflow;
  logic [3:0] count;
  logic [8:0] din;

  // Stand-in for the FIFO8x9 storage array
  logic [8:0] mem [DEPTH];
  logic [2:0] f_wp, f_rp;
  logic [8:0] dout;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  logic [8:0] q[$];
  bit         m_clear;
  int         m_wi, m_ri;

  // Expected / observed values of the last cycle
  bit         e_wren, e_wrinc, e_wrclr, e_rden, e_rdinc, e_rdclr, e_chk_clr;
  bit         e_rdv, e_ovf, e_udf;
  logic [3:0] e_count;
  logic [8:0] e_dout;
  logic       o_wren, o_wrinc, o_wrclr, o_rden, o_rdinc, o_rdclr;
  logic       o_rdv, o_ovf, o_udf, o_full, o_empty;
  logic [3:0] o_count;
  logic [8:0] o_dout;

  fifo8x9_ctrl #(.DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .wren(wren), .WrInc(WrInc), .WrPtrClr(WrPtrClr),
    .rden(rden), .RdInc(RdInc), .RdPtrClr(RdPtrClr),
    .full(full), .empty(empty), .count(count),
    .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (wren) mem[f_wp] <= din;
    if (WrPtrClr) f_wp <= 3'd0;
    else if (WrInc) f_wp <= f_wp + 3'd1;
    if (rden) dout <= mem[f_rp];
    if (RdPtrClr) f_rp <= 3'd0;
    else if (RdInc) f_rp <= f_rp + 3'd1;
  end

  // One clock cycle: drive at the falling edge, sample strobes 1ns later,
  // let the rising edge happen, sample registered outputs at the next falling edge.
  task automatic cycle(input bit r, input bit pu, input bit po, input bit fl, input logic [8:0] d);
    bit pop_ok, push_ok;
    rst = r; push = pu; pop = po; flush = fl; din = d;
    #1;
    o_wren = wren; o_wrinc = WrInc; o_wrclr = WrPtrClr;
    o_rden = rden; o_rdinc = RdInc; o_rdclr = RdPtrClr;
    e_chk_clr = 1; e_wren = 0; e_wrinc = 0; e_wrclr = 0;
    e_rden = 0; e_rdinc = 0; e_rdclr = 0; e_rdv = 0; e_ovf = 0; e_udf = 0;
    if (r) begin
      e_chk_clr = 0; q.delete(); m_wi = 0; m_ri = 0; m_clear = 1;
    end else if (m_clear) begin
      e_wrclr = 1; e_rdclr = 1; m_clear = 0; m_wi = 0; m_ri = 0;
    end else if (fl) begin
      q.delete(); m_clear = 1;
    end else begin
      pop_ok  = po && (q.size() > 0);
      push_ok = pu && ((q.size() < DEPTH) || pop_ok);
      e_wren  = push_ok; e_wrclr = push_ok && (m_wi == DEPTH - 1); e_wrinc = push_ok && !e_wrclr;
      e_rden  = pop_ok;  e_rdclr = pop_ok && (m_ri == DEPTH - 1);  e_rdinc = pop_ok && !e_rdclr;
      e_ovf = pu && !push_ok; e_udf = po && !pop_ok; e_rdv = pop_ok;
      if (pop_ok) begin e_dout = q.pop_front(); m_ri = (m_ri + 1) % DEPTH; end
      if (push_ok) begin q.push_back(d); m_wi = (m_wi + 1) % DEPTH; end
    end
    e_count = 4'(q.size());
    @(posedge clk);
    @(negedge clk);
    o_count = count; o_full = full; o_empty = empty;
    o_rdv = rd_valid; o_ovf = overflow; o_udf = underflow; o_dout = dout;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 9'h0);
    cycle(1, 1, 1, 0, 9'h0);
    n_vec++; if (o_wren !== 1'b0 || o_rden !== 1'b0) begin n_err++; $display("FAIL reset_strobes wren=%b rden=%b exp 0 0", o_wren, o_rden); end
    n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", o_count); end
    n_vec++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin n_err++; $display("FAIL reset_flags empty=%b full=%b exp 1 0", o_empty, o_full); end
    n_vec++; if (o_rdv !== 1'b0 || o_ovf !== 1'b0 || o_udf !== 1'b0) begin n_err++; $display("FAIL reset_pulses rdv=%b ovf=%b udf=%b exp 0 0 0", o_rdv, o_ovf, o_udf); end
    cycle(0, 1, 1, 0, 9'h1FF);  // CLEAR cycle: requests ignored
    n_vec++; if (o_wrclr !== 1'b1 || o_rdclr !== 1'b1) begin n_err++; $display("FAIL clear_ptrclr wr=%b rd=%b exp 1 1", o_wrclr, o_rdclr); end
    n_vec++; if ({o_wren, o_wrinc, o_rden, o_rdinc} !== 4'b0) begin n_err++; $display("FAIL clear_strobes got %b exp 0000", {o_wren, o_wrinc, o_rden, o_rdinc}); end
    n_vec++; if (o_ovf !== 1'b0 || o_udf !== 1'b0 || o_count !== 4'd0) begin n_err++; $display("FAIL clear_after ovf=%b udf=%b cnt=%0d exp 0 0 0", o_ovf, o_udf, o_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 9'h101 + 9'(i));
      n_vec++; if (o_wren !== 1'b1) begin n_err++; $display("FAIL fill_wren[%0d] got %b exp 1", i, o_wren); end
      n_vec++; if (o_wrclr !== (i == 7) || o_wrinc !== (i != 7)) begin n_err++; $display("FAIL fill_ptr[%0d] clr=%b inc=%b exp %b %b", i, o_wrclr, o_wrinc, i == 7, i != 7); end
      n_vec++; if (o_count !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, o_count, i + 1); end
    end
    n_vec++; if (o_full !== 1'b1 || o_empty !== 1'b0) begin n_err++; $display("FAIL fill_full full=%b empty=%b exp 1 0", o_full, o_empty); end
    cycle(0, 1, 0, 0, 9'h109);
    n_vec++; if (o_wren !== 1'b0) begin n_err++; $display("FAIL ovf_wren got %b exp 0", o_wren); end
    n_vec++; if (o_ovf !== 1'b1 || o_count !== 4'd8) begin n_err++; $display("FAIL ovf_pulse ovf=%b cnt=%0d exp 1 8", o_ovf, o_count); end
    cycle(0, 0, 0, 0, 9'h0);
    n_vec++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_single got %b exp 0", o_ovf); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0, 9'h0);
      n_vec++; if (o_rden !== 1'b1) begin n_err++; $display("FAIL drain_rden[%0d] got %b exp 1", i, o_rden); end
      n_vec++; if (o_rdclr !== (i == 7) || o_rdinc !== (i != 7)) begin n_err++; $display("FAIL drain_ptr[%0d] clr=%b inc=%b exp %b %b", i, o_rdclr, o_rdinc, i == 7, i != 7); end
      n_vec++; if (o_rdv !== 1'b1 || o_dout !== 9'h101 + 9'(i)) begin n_err++; $display("FAIL drain_data[%0d] rdv=%b dout=%h exp 1 %h", i, o_rdv, o_dout, 9'h101 + 9'(i)); end
    end
    n_vec++; if (o_empty !== 1'b1 || o_count !== 4'd0) begin n_err++; $display("FAIL drain_empty empty=%b cnt=%0d exp 1 0", o_empty, o_count); end
    cycle(0, 0, 1, 0, 9'h0);
    n_vec++; if (o_rden !== 1'b0 || o_udf !== 1'b1) begin n_err++; $display("FAIL udf rden=%b udf=%b exp 0 1", o_rden, o_udf); end
    cycle(0, 0, 0, 0, 9'h0);
    n_vec++; if (o_udf !== 1'b0 || o_rdv !== 1'b0) begin n_err++; $display("FAIL udf_single udf=%b rdv=%b exp 0 0", o_udf, o_rdv); end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] exp_seq [8] = '{9'h102, 9'h103, 9'h104, 9'h105, 9'h106, 9'h107, 9'h108, 9'h1AA};
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 9'h101 + 9'(i));
    cycle(0, 1, 1, 0, 9'h1AA);
    n_vec++; if (o_wren !== 1'b1 || o_rden !== 1'b1) begin n_err++; $display("FAIL fullpp_strobes wren=%b rden=%b exp 1 1", o_wren, o_rden); end
    n_vec++; if (o_dout !== 9'h101 || o_rdv !== 1'b1) begin n_err++; $display("FAIL fullpp_data dout=%h rdv=%b exp 101 1", o_dout, o_rdv); end
    n_vec++; if (o_count !== 4'd8 || o_ovf !== 1'b0) begin n_err++; $display("FAIL fullpp_count cnt=%0d ovf=%b exp 8 0", o_count, o_ovf); end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0, 9'h0);
      n_vec++; if (o_dout !== exp_seq[i]) begin n_err++; $display("FAIL fullpp_drain[%0d] got %h exp %h", i, o_dout, exp_seq[i]); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 9'($urandom));
    n_vec++; if (o_count !== 4'd5) begin n_err++; $display("FAIL flush_pre cnt=%0d exp 5", o_count); end
    cycle(0, 1, 1, 1, 9'h033);
    n_vec++; if ({o_wren, o_rden, o_wrclr, o_rdclr} !== 4'b0) begin n_err++; $display("FAIL flush_strobes got %b exp 0000", {o_wren, o_rden, o_wrclr, o_rdclr}); end
    n_vec++; if (o_count !== 4'd0 || o_ovf !== 1'b0 || o_udf !== 1'b0) begin n_err++; $display("FAIL flush_after cnt=%0d ovf=%b udf=%b exp 0 0 0", o_count, o_ovf, o_udf); end
    cycle(0, 0, 0, 0, 9'h0);
    n_vec++; if (o_wrclr !== 1'b1 || o_rdclr !== 1'b1) begin n_err++; $display("FAIL flush_clear wr=%b rd=%b exp 1 1", o_wrclr, o_rdclr); end
    cycle(0, 1, 0, 0, 9'h055);
    cycle(0, 0, 1, 0, 9'h0);
    n_vec++; if (o_rdv !== 1'b1 || o_dout !== 9'h055) begin n_err++; $display("FAIL flush_readback rdv=%b dout=%h exp 1 055", o_rdv, o_dout); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] v [3];
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 9'($urandom));
    cycle(1, 1, 1, 0, 9'h0);
    n_vec++; if (o_count !== 4'd0 || o_empty !== 1'b1 || o_rdv !== 1'b0) begin n_err++; $display("FAIL midrst cnt=%0d empty=%b rdv=%b exp 0 1 0", o_count, o_empty, o_rdv); end
    cycle(0, 0, 0, 0, 9'h0);
    n_vec++; if (o_wrclr !== 1'b1 || o_rdclr !== 1'b1) begin n_err++; $display("FAIL midrst_clear wr=%b rd=%b exp 1 1", o_wrclr, o_rdclr); end
    for (int i = 0; i < 3; i++) begin v[i] = 9'($urandom); cycle(0, 1, 0, 0, v[i]); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 9'h0);
      n_vec++; if (o_rdv !== 1'b1 || o_dout !== v[i]) begin n_err++; $display("FAIL midrst_order[%0d] rdv=%b dout=%h exp 1 %h", i, o_rdv, o_dout, v[i]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 79) == 0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            $urandom_range(0, 39) == 0, 9'($urandom));
      n_vec++; if ({o_wren, o_wrinc, o_rden, o_rdinc} !== {e_wren, e_wrinc, e_rden, e_rdinc}) begin n_err++; $display("FAIL rnd_strobes[%0d] got %b exp %b", n, {o_wren, o_wrinc, o_rden, o_rdinc}, {e_wren, e_wrinc, e_rden, e_rdinc}); end
      if (e_chk_clr) begin
        n_vec++; if ({o_wrclr, o_rdclr} !== {e_wrclr, e_rdclr}) begin n_err++; $display("FAIL rnd_ptrclr[%0d] got %b exp %b", n, {o_wrclr, o_rdclr}, {e_wrclr, e_rdclr}); end
      end
      n_vec++; if (o_count !== e_count || o_full !== (e_count == 4'd8) || o_empty !== (e_count == 4'd0)) begin n_err++; $display("FAIL rnd_count[%0d] cnt=%0d full=%b empty=%b exp cnt %0d", n, o_count, o_full, o_empty, e_count); end
      n_vec++; if ({o_rdv, o_ovf, o_udf} !== {e_rdv, e_ovf, e_udf}) begin n_err++; $display("FAIL rnd_pulses[%0d] got %b exp %b", n, {o_rdv, o_ovf, o_udf}, {e_rdv, e_ovf, e_udf}); end
      if (e_rdv) begin
        n_vec++; if (o_dout !== e_dout) begin n_err++; $display("FAIL rnd_data[%0d] got %h exp %h", n, o_dout, e_dout); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; din = 9'h0;
    m_clear = 1; m_wi = 0; m_ri = 0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
